// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// Module  : pipe_pkg
// Brief   : Shared types and helpers for the generic pipeline stage buffer.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  localparam int TNEW_W_DEFAULT = 2;
  // Tnew is carried padded to this width so one helper serves every TNEW_W.
  localparam int TNEW_W_MAX     = 8;

  typedef logic [TNEW_W_MAX-1:0] tnew_t;

  typedef struct packed {
    logic  valid;
    logic  bubble;
    tnew_t tnew;
  } slot_meta_t;

  function automatic tnew_t sat_dec(input tnew_t v);
    return (v == '0) ? '0 : v - tnew_t'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// Module  : pipe_slot
// Brief   : One stage-buffer slot: {valid, bubble, tnew, data} with clear/load/age.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 160,
  parameter int TNEW_W = TNEW_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              age_i,
  input  logic              ld_bubble_i,
  input  logic [TNEW_W-1:0] ld_tnew_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              valid_o,
  output logic              bubble_o,
  output logic [TNEW_W-1:0] tnew_o,
  output logic [DATA_W-1:0] data_o
);

  slot_meta_t        meta_q, meta_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Valid only changes through clear or load, so an invalid slot stays all-zero.
  always_comb begin
    meta_d = meta_q;
    data_d = data_q;
    if (clear_i) begin
      meta_d = '0;
      data_d = '0;
    end else if (load_i) begin
      meta_d.valid  = 1'b1;
      meta_d.bubble = ld_bubble_i;
      meta_d.tnew   = tnew_t'(ld_tnew_i);
      data_d        = ld_data_i;
    end else if (age_i && meta_q.valid) begin
      meta_d.tnew = sat_dec(meta_q.tnew);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      data_q <= '0;
    end else begin
      meta_q <= meta_d;
      data_q <= data_d;
    end
  end

  assign valid_o  = meta_q.valid;
  assign bubble_o = meta_q.bubble;
  assign tnew_o   = TNEW_W'(meta_q.tnew);
  assign data_o   = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// Module  : pipe_stage_buf
// Brief   : Generic pipeline stage register with bubble keep-mask, Tnew countdown
//           and a one-entry skid buffer. Optional: PIPE_STAGE_BUF_TNEW_AGE_EN.
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int              DATA_W    = 160,
  parameter logic [DATA_W-1:0] KEEP_MASK = {DATA_W{1'b0}},
  parameter int              TNEW_W    = TNEW_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_all,
  input  logic              bubble,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TNEW_W-1:0] in_tnew,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TNEW_W-1:0] out_tnew,
  output logic              out_bubble
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

`ifdef PIPE_STAGE_BUF_TNEW_AGE_EN
  localparam logic AGE_EN = 1'b1;
`else
  localparam logic AGE_EN = 1'b0;
`endif

  logic              in_ready_q, in_ready_d;
  logic              main_v, main_b, skid_v, skid_b;
  logic [TNEW_W-1:0] main_t, skid_t;
  logic [DATA_W-1:0] main_dat, skid_dat;
  logic [1:0]        state;
  logic              accept, drain;
  logic              main_load, main_from_skid, main_clear, skid_load, skid_clear;
  logic              skid_valid_d;

  logic              new_bubble;
  logic [TNEW_W-1:0] new_tnew;
  logic [DATA_W-1:0] new_data;

  logic              main_ld_b;
  logic [TNEW_W-1:0] main_ld_t;
  logic [DATA_W-1:0] main_ld_d;

  assign state  = {skid_v, main_v};
  assign accept = in_valid & in_ready_q;
  assign drain  = main_v & out_ready;

  // A bubble keeps only the masked fields and never carries a pending result.
  assign new_bubble = bubble;
  assign new_tnew   = bubble ? '0 : TNEW_W'(sat_dec(tnew_t'(in_tnew)));
  assign new_data   = bubble ? (in_data & KEEP_MASK) : in_data;

  always_comb begin
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush_all) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) main_load = 1'b1;
        end
        ST_ONE: begin
          if (accept && drain)  main_load  = 1'b1;
          else if (accept)      skid_load  = 1'b1;
          else if (drain)       main_clear = 1'b1;
        end
        ST_FULL: begin
          if (drain) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          // SKID without MAIN is unreachable; fall back to empty.
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_ld_b = main_from_skid ? skid_b   : new_bubble;
  assign main_ld_t = main_from_skid ? skid_t   : new_tnew;
  assign main_ld_d = main_from_skid ? skid_dat : new_data;

  assign skid_valid_d = !flush_all && (skid_load || (skid_v && !skid_clear));
  assign in_ready_d   = !skid_valid_d;

  always_ff @(posedge clk) begin
    if (reset) in_ready_q <= 1'b1;
    else       in_ready_q <= in_ready_d;
  end

  pipe_slot #(
    .DATA_W (DATA_W),
    .TNEW_W (TNEW_W)
  ) u_main (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (main_clear),
    .load_i      (main_load),
    .age_i       (AGE_EN & ~main_load & ~main_clear),
    .ld_bubble_i (main_ld_b),
    .ld_tnew_i   (main_ld_t),
    .ld_data_i   (main_ld_d),
    .valid_o     (main_v),
    .bubble_o    (main_b),
    .tnew_o      (main_t),
    .data_o      (main_dat)
  );

  pipe_slot #(
    .DATA_W (DATA_W),
    .TNEW_W (TNEW_W)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (skid_clear),
    .load_i      (skid_load),
    .age_i       (AGE_EN & ~skid_load & ~skid_clear),
    .ld_bubble_i (new_bubble),
    .ld_tnew_i   (new_tnew),
    .ld_data_i   (new_data),
    .valid_o     (skid_v),
    .bubble_o    (skid_b),
    .tnew_o      (skid_t),
    .data_o      (skid_dat)
  );

  assign in_ready   = in_ready_q;
  assign out_valid  = main_v;
  assign out_data   = main_dat;
  assign out_tnew   = main_t;
  assign out_bubble = main_b;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// Module  : tb_pipe_stage_buf
// Brief   : Directed vector bench for pipe_stage_buf (DATA_W=40, upper-24-bit keep mask).
// Revision: 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_buf;

  localparam int               DATA_W    = 40;
  localparam int               TNEW_W    = 2;
  localparam logic [DATA_W-1:0] KEEP_MASK = 40'hFF_FFFF_0000;
`ifdef PIPE_STAGE_BUF_TNEW_AGE_EN
  localparam bit AGE = 1'b1;
`else
  localparam bit AGE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, flush_all, bubble, in_valid, out_ready;
  logic [DATA_W-1:0] in_data;
  logic [TNEW_W-1:0] in_tnew;
  logic              in_ready, out_valid, out_bubble;
  logic [DATA_W-1:0] out_data;
  logic [TNEW_W-1:0] out_tnew;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(
    .DATA_W    (DATA_W),
    .KEEP_MASK (KEEP_MASK),
    .TNEW_W    (TNEW_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush_all  (flush_all),
    .bubble     (bubble),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_tnew    (in_tnew),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tnew   (out_tnew),
    .out_bubble (out_bubble)
  );

  typedef struct {
    logic              fl;
    logic              bub;
    logic              iv;
    logic              ordy;
    logic [DATA_W-1:0] din;
    logic [TNEW_W-1:0] tin;
    logic              e_ov;
    logic              e_ir;
    logic [DATA_W-1:0] e_dat;
    logic [TNEW_W-1:0] e_tn;
    logic              e_b;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic e_ov, input logic e_ir,
                           input logic [DATA_W-1:0] e_dat, input logic [TNEW_W-1:0] e_tn,
                           input logic e_b);
    check({tag, ".out_valid"},  64'(out_valid),  64'(e_ov));
    check({tag, ".in_ready"},   64'(in_ready),   64'(e_ir));
    check({tag, ".out_data"},   64'(out_data),   64'(e_dat));
    check({tag, ".out_tnew"},   64'(out_tnew),   64'(e_tn));
    check({tag, ".out_bubble"}, 64'(out_bubble), 64'(e_b));
  endtask

  task automatic drive(input logic fl, input logic bub, input logic iv, input logic ordy,
                       input logic [DATA_W-1:0] din, input logic [TNEW_W-1:0] tin);
    flush_all = fl;
    bubble    = bub;
    in_valid  = iv;
    out_ready = ordy;
    in_data   = din;
    in_tnew   = tin;
  endtask

  initial begin
    //          fl bub iv ordy din               tin    ov ir dat               tn     b
    vecs[0]  = '{0, 0, 1, 1, 40'hAA_0000_ABCD, 2'd2, 1, 1, 40'hAA_0000_ABCD, 2'd1, 0};
    vecs[1]  = '{0, 0, 0, 1, 40'h0,            2'd0, 0, 1, 40'h0,            2'd0, 0};
    vecs[2]  = '{0, 0, 1, 0, 40'h00_0000_0011, 2'd1, 1, 1, 40'h00_0000_0011, 2'd0, 0};
    vecs[3]  = '{0, 0, 1, 0, 40'h00_0000_0022, 2'd0, 1, 0, 40'h00_0000_0011, 2'd0, 0};
    vecs[4]  = '{0, 0, 1, 0, 40'h00_0000_0033, 2'd1, 1, 0, 40'h00_0000_0011, 2'd0, 0};
    vecs[5]  = '{0, 0, 1, 1, 40'h00_0000_0033, 2'd1, 1, 1, 40'h00_0000_0022, 2'd0, 0};
    vecs[6]  = '{0, 0, 1, 1, 40'h00_0000_0033, 2'd1, 1, 1, 40'h00_0000_0033, 2'd0, 0};
    vecs[7]  = '{0, 1, 1, 1, 40'hA5_1234_5678, 2'd3, 1, 1, 40'hA5_1234_0000, 2'd0, 1};
    vecs[8]  = '{0, 0, 0, 0, 40'h0,            2'd0, 1, 1, 40'hA5_1234_0000, 2'd0, 1};
    vecs[9]  = '{0, 0, 0, 1, 40'h0,            2'd0, 0, 1, 40'h0,            2'd0, 0};
    vecs[10] = '{0, 0, 1, 0, 40'h00_0000_0055, 2'd1, 1, 1, 40'h00_0000_0055, 2'd0, 0};
    vecs[11] = '{0, 0, 1, 0, 40'h00_0000_0066, 2'd2, 1, 0, 40'h00_0000_0055, 2'd0, 0};
    vecs[12] = '{1, 0, 1, 1, 40'h00_0000_0077, 2'd1, 0, 1, 40'h0,            2'd0, 0};
    vecs[13] = '{0, 0, 0, 0, 40'h0,            2'd0, 0, 1, 40'h0,            2'd0, 0};
    vecs[14] = '{1, 0, 1, 0, 40'h00_0000_0088, 2'd2, 0, 1, 40'h0,            2'd0, 0};
    vecs[15] = '{0, 1, 1, 0, 40'h00_0000_0099, 2'd0, 1, 1, 40'h0,            2'd0, 1};
    vecs[16] = '{0, 0, 0, 1, 40'h0,            2'd0, 0, 1, 40'h0,            2'd0, 0};

    reset = 1'b1;
    drive(0, 0, 0, 0, '0, '0);
    tick();
    tick();
    check_all("reset", 0, 1, '0, '0, 0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].fl, vecs[i].bub, vecs[i].iv, vecs[i].ordy, vecs[i].din, vecs[i].tin);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir,
                vecs[i].e_dat, vecs[i].e_tn, vecs[i].e_b);
    end

    // Stalled entry: Tnew holds by default, counts down with aging enabled.
    drive(0, 0, 1, 0, 40'h00_0000_0044, 2'd3);
    tick();
    check_all("age0", 1, 1, 40'h00_0000_0044, 2'd2, 0);
    drive(0, 0, 0, 0, '0, '0);
    tick();
    check_all("age1", 1, 1, 40'h00_0000_0044, AGE ? 2'd1 : 2'd2, 0);
    tick();
    check_all("age2", 1, 1, 40'h00_0000_0044, AGE ? 2'd0 : 2'd2, 0);
    tick();
    check_all("age3", 1, 1, 40'h00_0000_0044, AGE ? 2'd0 : 2'd2, 0);

    // Fill to FULL, then reset together with flush and a presented entry.
    drive(0, 0, 1, 0, 40'h00_0000_0045, 2'd1);
    tick();
    check("full.in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    drive(1, 0, 1, 0, 40'hFF_FFFF_FFFF, 2'd3);
    tick();
    check_all("rst_flush", 0, 1, '0, '0, 0);
    reset = 1'b0;
    drive(0, 0, 0, 0, '0, '0);
    tick();
    check_all("post_rst", 0, 1, '0, '0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed per-stage pipeline registers (D/E, E/M, M/W) of the P7 MIPS CPU.
- One generic stage register for any boundary, with:
  - a configurable payload width;
  - a keep-mask that selects which fields survive bubble insertion;
  - saturating Tnew countdown;
  - a valid/ready handshake backed by a one-entry skid buffer, so upstream stall need not be combinational.
- Sits between two pipeline stages; the payload is the concatenated control and data fields of that boundary.

Parameters:
- DATA_W, 160, payload width in bits.
- KEEP_MASK, {DATA_W{1'b0}}, per-bit mask of fields kept on bubble insertion (PC, branch-delay flag); all other bits are zeroed.
- TNEW_W, 2, width of the Tnew field.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush_all  in  1  exception/eret flush; clears all stored state.
- bubble  in  1  the entry loaded this cycle becomes a nop that carries only the KEEP_MASK fields.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  stage can accept an entry; registered.
- in_data  in  DATA_W  upstream payload.
- in_tnew  in  TNEW_W  upstream Tnew.
- out_valid  out  1  main slot holds an entry.
- out_ready  in  1  downstream accepts the entry this cycle.
- out_data  out  DATA_W  main slot payload.
- out_tnew  out  TNEW_W  main slot Tnew.
- out_bubble  out  1  main slot entry is an inserted nop.

Behaviour:
- Clock and reset:
  - Clock is clk; reset is reset, synchronous, active-high.
  - On reset, all outputs are 0 except in_ready, which is 1. Both slots are invalid and zeroed.
- State:
  - Two slots, MAIN and SKID; each holds {valid, bubble, tnew, data}.
  - Occupancy states: EMPTY (neither slot valid), ONE (MAIN only), FULL (MAIN and SKID). SKID is never valid while MAIN is invalid.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Drain = out_valid & out_ready.
  - in_ready is registered: next value = !(SKID valid in the next state).
- Loaded-entry formation, applied on every accept:
  - tnew = (in_tnew==0) ? 0 : in_tnew-1.
  - If bubble=1: data = in_data & KEEP_MASK, tnew = 0, bubble flag = 1.
  - If bubble=0: data = in_data, bubble flag = 0.
- Transitions:
  - EMPTY, accept → ONE.
  - ONE, accept & drain → ONE; MAIN takes the new entry.
  - ONE, accept & !drain → FULL; SKID takes the new entry.
  - ONE, drain & !accept → EMPTY.
  - FULL, drain → ONE; MAIN ← SKID and SKID clears. No accept is possible in FULL because in_ready=0.
- Priority: reset > flush_all > normal operation.
  - flush_all: both slots are cleared to zero and the next state is EMPTY, whatever in_valid and out_ready are. An entry presented in the same cycle is dropped.
- Latency and throughput: 1 cycle from accept to out_valid when the stage is EMPTY or draining. Sustained throughput is 1 entry per cycle.
- Payload stability: out_data, out_tnew and out_bubble are stable while out_valid=1 and out_ready=0. The only exception is tnew aging under the optional feature.
- Invalid slots always present zero payload.
- Reset or flush_all asserted in FULL discards both entries; the following cycle has in_ready=1.

Optional Feature:
- Macro: PIPE_STAGE_BUF_TNEW_AGE_EN.
- When defined, each valid slot that does not move in a cycle has its tnew saturating-decremented by 1. This models a producer whose result completes while stalled.
- When undefined, tnew changes only on load.

Decomposition:
- Package pipe_pkg:
  - function sat_dec (saturating decrement of a TNEW_W-bit value);
  - localparam TNEW_W_DEFAULT = 2;
  - typedef of the slot struct {valid, bubble, tnew}.
- Sub-module pipe_slot: one slot register with load, clear and age controls. It is instantiated twice, for MAIN and SKID.

Test Plan:
- Reset, then in_valid=1, in_data=0x…ABCD, in_tnew=2, out_ready=1 → next cycle out_valid=1, out_data=0x…ABCD, out_tnew=1, out_bubble=0.
- Three back-to-back accepts with out_ready=0 from the second cycle → FULL, in_ready=0 the cycle after the second accept. Raise out_ready → entries leave in order, one per cycle, and in_ready=1 again one cycle after SKID empties.
- KEEP_MASK=0x…FFFF0000, bubble=1, in_data=0x…12345678, in_tnew=3 → out_data=0x…12340000, out_tnew=0, out_bubble=1.
- FULL state, flush_all=1 with in_valid=1 → next cycle out_valid=0, out_data=0, in_ready=1, and the new entry is absent.
- in_tnew=0 → out_tnew=0 (no wrap to 3). With PIPE_STAGE_BUF_TNEW_AGE_EN, in_tnew=3 held 3 cycles with out_ready=0 → out_tnew shows 2, 1, 0, 0.
- reset and flush_all asserted together with in_valid=1 → identical to reset; all outputs 0 and in_ready=1.
